// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH:0]   r_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;
    logic             carry;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // The restored remainder is always below the divisor, so its top bit never feeds the shift.
    logic unused_r_msb;
    assign unused_r_msb = r_q[WIDTH];

    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial   = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign carry   = trial[WIDTH+1];
    assign q_d     = {q_q[WIDTH-2:0], carry};
    assign r_d     = carry ? trial[WIDTH:0] : r_shift;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quot_q;
    logic neg_rem_q;

    assign a_mag    = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign b_mag    = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign quot_fix = neg_quot_q ? (~q_d + 1'b1) : q_d;
    assign rem_fix  = neg_rem_q  ? (~r_d[WIDTH-1:0] + 1'b1) : r_d[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (start && !busy) begin
            neg_quot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q  <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag    = dividend;
    assign b_mag    = divisor;
    assign quot_fix = q_d;
    assign rem_fix  = r_d[WIDTH-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        q_q   <= a_mag;
                        d_q   <= b_mag;
                        r_q   <= '0;
                        cnt_q <= CW'(WIDTH);
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q   <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        quotient  <= quot_fix;
                        remainder <= rem_fix;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=4; signed vectors when SEQ_DIVIDER_SIGNED_EN is set.
module tb_seq_divider;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " done"}, done, 0);
        check_eq({tag, " quot"}, quotient, 0);
        check_eq({tag, " rem"}, remainder, 0);
        check_eq({tag, " dbz"}, div_by_zero, 0);
    endtask

    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int lat_start, input int exp_lat, input logic [W-1:0] exp_q,
                             input logic [W-1:0] exp_r, input logic exp_dbz, input bit idle_after);
        int lat;
        lat = lat_start;
        while (!done && lat < 20) begin
            check_eq({tag, " busy"}, busy, 1);
            step();
            lat++;
        end
        check_eq({tag, " lat"}, lat, exp_lat);
        check_eq({tag, " quot"}, quotient, exp_q);
        check_eq({tag, " rem"}, remainder, exp_r);
        check_eq({tag, " dbz"}, div_by_zero, exp_dbz);
        check_eq({tag, " busy@done"}, busy, 0);
        $display("op %s: %h/%h -> q=%h r=%h dbz=%b lat=%0d", tag, a, b, quotient, remainder,
                 div_by_zero, lat);
        if (idle_after) begin
            step();
            check_eq({tag, " pulse"}, done, 0);
        end
    endtask

    // Called at a sample point; the following rising edge is the accepting edge.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                         input logic exp_dbz, input bit idle_after);
        start = 1'b1; dividend = a; divisor = b;
        step();
        start = 1'b0; dividend = '0; divisor = '0;
        if (b != '0) check_eq({tag, " done@accept"}, done, 0);
        finish_op(tag, a, b, 0, exp_lat, exp_q, exp_r, exp_dbz, idle_after);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        check_idle_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_op("-7/2",  4'b1001, 4'd2,    4, 4'b1101, 4'b1111, 1'b0, 1'b1);
        do_op("-8/-1", 4'b1000, 4'b1111, 4, 4'b1000, 4'b0000, 1'b0, 1'b1);
        do_op("7/-2",  4'd7,    4'b1110, 4, 4'b1101, 4'b0001, 1'b0, 1'b0);
        do_op("-6/-3", 4'b1010, 4'b1101, 4, 4'b0010, 4'b0000, 1'b0, 1'b1);
        do_op("5/0s",  4'd5,    4'd0,    0, 4'hF,    4'd5,    1'b1, 1'b1);
        do_op("6/4s",  4'd6,    4'd4,    4, 4'd1,    4'd2,    1'b0, 1'b1);
`else
        do_op("13/3", 4'd13, 4'd3, 4, 4'd4,  4'd1, 1'b0, 1'b1);
        do_op("15/1", 4'd15, 4'd1, 4, 4'd15, 4'd0, 1'b0, 1'b0);
        do_op("2/7",  4'd2,  4'd7, 4, 4'd0,  4'd2, 1'b0, 1'b1);
        do_op("5/0",  4'd5,  4'd0, 0, 4'hF,  4'd5, 1'b1, 1'b1);
        do_op("9/4",  4'd9,  4'd4, 4, 4'd2,  4'd1, 1'b0, 1'b1);

        // Second request during RUN must be ignored.
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        step();
        start = 1'b0; dividend = '0; divisor = '0;
        step();
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        step();
        start = 1'b0; dividend = '0; divisor = '0;
        finish_op("12/5 ign", 4'd12, 4'd5, 2, 4, 4'd2, 4'd2, 1'b0, 1'b1);

        // Asynchronous reset mid-operation.
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        step();
        start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check_idle_zero("async rst");
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst no done", done, 0);
        end
        rst = 1'b0;
        do_op("14/3", 4'd14, 4'd3, 4, 4'd4, 4'd2, 1'b0, 1'b1);

        do_op("7/7",   4'd7,  4'd7,  4, 4'd1, 4'd0, 1'b0, 1'b1);
        do_op("3/10",  4'd3,  4'd10, 4, 4'd0, 4'd3, 1'b0, 1'b1);
        do_op("15/15", 4'd15, 4'd15, 4, 4'd1, 4'd0, 1'b0, 1'b1);
        do_op("0/0",   4'd0,  4'd0,  0, 4'hF, 4'd0, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
